// File: rtl/pll_ce_supervisor.sv
// PLL lock supervisor: drives PLL reset, qualifies lock, and derives N_CH phase-aligned clock-enable strobes.
// Latency: locked_i rise to ready_o is 3+LOCK_HOLD cycles; all outputs decode registered state only.
module pll_ce_supervisor #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int LOCK_HOLD = 1024,
  parameter int TIMEOUT   = 65536,
  parameter int RST_PULSE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  locked_i,
  input  logic                  restart_i,
  input  logic [N_CH*CNT_W-1:0] div_i,
  input  logic [N_CH*CNT_W-1:0] phase_i,
  output logic                  pll_rst_o,
  output logic                  ready_o,
  output logic [N_CH-1:0]       ce_o,
  output logic [1:0]            state_o,
  output logic [7:0]            loss_cnt_o,
  output logic [7:0]            timeout_cnt_o
);

  localparam int MAX_AB = (TIMEOUT > LOCK_HOLD) ? TIMEOUT : LOCK_HOLD;
  localparam int MAXV   = (MAX_AB > RST_PULSE) ? MAX_AB : RST_PULSE;
  localparam int TMR_W  = (MAXV > 1) ? $clog2(MAXV) : 1;

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_QUALIFY   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic               sync1, lock_s;
  logic               latch, inc_loss, inc_to;
  logic               run;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= locked_i;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_RESET_PLL;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // One shared timer serves the reset pulse, the lock timeout and the hold count.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr + TMR_W'(1);
    latch     = 1'b0;
    inc_loss  = 1'b0;
    inc_to    = 1'b0;
    if (restart_i) begin
      state_nxt = S_RESET_PLL;
      tmr_nxt   = '0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (tmr == TMR_W'(RST_PULSE - 1)) begin
            state_nxt = S_WAIT_LOCK;
            tmr_nxt   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = S_QUALIFY;
            tmr_nxt   = '0;
          end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
            state_nxt = S_RESET_PLL;
            tmr_nxt   = '0;
            inc_to    = 1'b1;
          end
        end
        S_QUALIFY: begin
          if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
            tmr_nxt   = '0;
          end else if (tmr == TMR_W'(LOCK_HOLD - 1)) begin
            state_nxt = S_RUN;
            tmr_nxt   = '0;
            latch     = 1'b1;
          end
        end
        default: begin
          tmr_nxt = '0;
          if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
            inc_loss  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      loss_cnt_o    <= 8'd0;
      timeout_cnt_o <= 8'd0;
    end else begin
      if (inc_loss && loss_cnt_o != 8'hFF)
        loss_cnt_o <= loss_cnt_o + 8'd1;
      if (inc_to && timeout_cnt_o != 8'hFF)
        timeout_cnt_o <= timeout_cnt_o + 8'd1;
    end
  end

  assign run       = (state == S_RUN);
  assign ready_o   = run;
  assign pll_rst_o = (state == S_RESET_PLL);
  assign state_o   = state;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_W-1:0] div_k, phase_k, dm1_in, p_in;
    logic [CNT_W-1:0] dm1, cnt;

    assign div_k   = div_i[k*CNT_W +: CNT_W];
    assign phase_k = phase_i[k*CNT_W +: CNT_W];
    // Store D-1 directly; a zero divider behaves as divide-by-one.
    assign dm1_in  = (div_k == '0) ? '0 : div_k - CNT_W'(1);
    assign p_in    = (phase_k > dm1_in) ? '0 : phase_k;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        dm1 <= '0;
        cnt <= '0;
      end else if (latch) begin
        dm1 <= dm1_in;
        cnt <= p_in;
      end else if (run) begin
        cnt <= (cnt == dm1) ? '0 : cnt + CNT_W'(1);
      end
    end

    assign ce_o[k] = run && (cnt == dm1);
  end

endmodule

// File: tb/tb_pll_ce_supervisor.sv
// Directed bench for pll_ce_supervisor: lock acquisition, channel strobes, loss, glitch, restart, timeout, async reset.
module tb_pll_ce_supervisor;

  localparam int N_CH = 4;
  localparam int CNT_W = 16;
  localparam int LOCK_HOLD = 1024;
  localparam int TIMEOUT = 64;
  localparam int RST_PULSE = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  locked = 1'b0;
  logic                  restart = 1'b0;
  logic [N_CH*CNT_W-1:0] div = '0;
  logic [N_CH*CNT_W-1:0] phase = '0;
  logic                  pll_rst;
  logic                  ready;
  logic [N_CH-1:0]       ce;
  logic [1:0]            state;
  logic [7:0]            loss_cnt;
  logic [7:0]            timeout_cnt;

  int checks = 0;
  int passes = 0;

  pll_ce_supervisor #(
    .N_CH(N_CH), .CNT_W(CNT_W), .LOCK_HOLD(LOCK_HOLD), .TIMEOUT(TIMEOUT), .RST_PULSE(RST_PULSE)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .locked_i(locked), .restart_i(restart),
    .div_i(div), .phase_i(phase), .pll_rst_o(pll_rst), .ready_o(ready), .ce_o(ce),
    .state_o(state), .loss_cnt_o(loss_cnt), .timeout_cnt_o(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    div   = {16'd0, 16'd5, 16'd2, 16'd1};
    phase = {16'd7, 16'd3, 16'd1, 16'd0};
    rst_n = 1'b0;
    step(3);
    checks++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else passes++;
    checks++; if (pll_rst !== 1'b1 || ready !== 1'b0 || ce !== 4'h0)
      $display("FAIL reset_outs got pll_rst=%b ready=%b ce=%h want 1 0 0", pll_rst, ready, ce); else passes++;
    checks++; if (loss_cnt !== 8'd0 || timeout_cnt !== 8'd0)
      $display("FAIL reset_cnts got %0d %0d want 0 0", loss_cnt, timeout_cnt); else passes++;
    rst_n = 1'b1;
    begin
      int n = 0;
      while (pll_rst === 1'b1 && n < 100) begin step(1); n++; end
      checks++; if (n !== RST_PULSE) $display("FAIL rst_pulse_len got %0d want %0d", n, RST_PULSE); else passes++;
    end
    checks++; if (state !== 2'd1) $display("FAIL after_pulse_state got %0d want 1", state); else passes++;
  endtask

  // locked_i rises with the FSM freshly in WAIT_LOCK: RUN after 3+LOCK_HOLD edges.
  task automatic test_lock_acquire();
    int n = 0;
    locked = 1'b1;
    step(3);
    n = 3;
    checks++; if (state !== 2'd2) $display("FAIL qualify_entry got %0d want 2", state); else passes++;
    while (ready !== 1'b1 && n < 3000) begin step(1); n++; end
    checks++; if (n !== 3 + LOCK_HOLD) $display("FAIL lock_to_ready got %0d want %0d", n, 3 + LOCK_HOLD); else passes++;
    checks++; if (timeout_cnt !== 8'd0) $display("FAIL timeout_after_lock got %0d want 0", timeout_cnt); else passes++;
  endtask

  // Starts at the first RUN cycle; div/phase are changed mid-RUN and must be ignored.
  task automatic test_channels();
    logic [3:0] exp_ce [17] = '{4'hB, 4'hD, 4'hB, 4'h9, 4'hB, 4'h9, 4'hF, 4'h9, 4'hB,
                                4'h9, 4'hB, 4'hD, 4'hB, 4'h9, 4'hB, 4'h9, 4'hF};
    for (int c = 0; c < 17; c++) begin
      if (c == 12) begin
        div   = {16'd3, 16'd3, 16'd3, 16'd3};
        phase = '0;
      end
      checks++; if (ce !== exp_ce[c]) $display("FAIL ce_cycle%0d got %h want %h", c, ce, exp_ce[c]); else passes++;
      step(1);
    end
  endtask

  task automatic test_lock_loss();
    locked = 1'b0;
    step(2);
    checks++; if (ready !== 1'b1 || ce[0] !== 1'b1)
      $display("FAIL loss_2cyc got ready=%b ce0=%b want 1 1", ready, ce[0]); else passes++;
    step(1);
    checks++; if (ready !== 1'b0 || ce !== 4'h0)
      $display("FAIL loss_3cyc got ready=%b ce=%h want 0 0", ready, ce); else passes++;
    checks++; if (state !== 2'd1) $display("FAIL loss_state got %0d want 1", state); else passes++;
    checks++; if (loss_cnt !== 8'd1) $display("FAIL loss_cnt got %0d want 1", loss_cnt); else passes++;
  endtask

  task automatic test_qualify_glitch();
    int n;
    locked = 1'b1;
    step(3);
    checks++; if (state !== 2'd2) $display("FAIL glitch_pre_state got %0d want 2", state); else passes++;
    step(100);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(2);
    n = 2;
    checks++; if (state !== 2'd1) $display("FAIL glitch_back_wait got %0d want 1", state); else passes++;
    while (ready !== 1'b1 && n < 3000) begin step(1); n++; end
    checks++; if (n !== 3 + LOCK_HOLD) $display("FAIL glitch_full_hold got %0d want %0d", n, 3 + LOCK_HOLD); else passes++;
    checks++; if (loss_cnt !== 8'd1) $display("FAIL glitch_loss_cnt got %0d want 1", loss_cnt); else passes++;
  endtask

  task automatic test_restart();
    int n = 0;
    restart = 1'b1;
    locked  = 1'b0;
    step(1);
    restart = 1'b0;
    checks++; if (state !== 2'd0) $display("FAIL restart_state got %0d want 0", state); else passes++;
    while (pll_rst === 1'b1 && n < 100) begin step(1); n++; end
    checks++; if (n !== RST_PULSE) $display("FAIL restart_pulse got %0d want %0d", n, RST_PULSE); else passes++;
    checks++; if (loss_cnt !== 8'd1) $display("FAIL restart_loss_cnt got %0d want 1", loss_cnt); else passes++;
  endtask

  task automatic test_timeout();
    int n = 0;
    while (state !== 2'd0 && n < 200) begin step(1); n++; end
    checks++; if (n !== TIMEOUT) $display("FAIL timeout_len got %0d want %0d", n, TIMEOUT); else passes++;
    checks++; if (timeout_cnt !== 8'd1) $display("FAIL timeout_cnt1 got %0d want 1", timeout_cnt); else passes++;
    n = 0;
    while (state !== 2'd1 && n < 200) begin step(1); n++; end
    checks++; if (n !== RST_PULSE) $display("FAIL timeout_rst_len got %0d want %0d", n, RST_PULSE); else passes++;
    step(RST_PULSE + TIMEOUT);
    checks++; if (timeout_cnt !== 8'd2) $display("FAIL timeout_cnt2 got %0d want 2", timeout_cnt); else passes++;
    step(260 * (RST_PULSE + TIMEOUT));
    checks++; if (timeout_cnt !== 8'd255) $display("FAIL timeout_sat got %0d want 255", timeout_cnt); else passes++;
    checks++; if (loss_cnt !== 8'd1) $display("FAIL timeout_loss_cnt got %0d want 1", loss_cnt); else passes++;
  endtask

  task automatic test_async_reset();
    int n = 0;
    locked = 1'b1;
    while (ready !== 1'b1 && n < 3000) begin step(1); n++; end
    checks++; if (ready !== 1'b1) $display("FAIL arst_pre_run got ready=%b want 1", ready); else passes++;
    step(5);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || pll_rst !== 1'b1 || ready !== 1'b0 || ce !== 4'h0)
      $display("FAIL arst_outs got st=%0d pll_rst=%b ready=%b ce=%h want 0 1 0 0", state, pll_rst, ready, ce); else passes++;
    checks++; if (loss_cnt !== 8'd0 || timeout_cnt !== 8'd0)
      $display("FAIL arst_cnts got %0d %0d want 0 0", loss_cnt, timeout_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_channels();
    test_lock_loss();
    test_qualify_glitch();
    test_restart();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
